motor_drive_ctrl: RTL

MOTOR_DRIVE_CTRL -- requirements
Module: motor_drive_ctrl

---
 rtl/motor_drive_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/motor_drive_ctrl.sv
// Two-wheel motor drive: mode decoder, shared PWM counter, per-wheel OFF/RUN/DEAD FSMs.
// Optional soft-start ramp compiled in with `define MOTOR_SOFT_RAMP_EN.
module motor_drive_ctrl #(
  parameter int unsigned PWM_BITS  = 10,
  parameter int unsigned DUTY_FULL = 10'd700,
  parameter int unsigned DUTY_SLOW = 10'd450,
  parameter int unsigned RAMP_DIV  = 20000,
  parameter int unsigned DEADTIME  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] mode,
  output logic       pwm_l,
  output logic       pwm_r,
  output logic [1:0] l_in,
  output logic [1:0] r_in,
  output logic       dead_l,
  output logic       dead_r
);
  localparam int unsigned DUTY_MAX = (1 << PWM_BITS) - 1;
  localparam logic [PWM_BITS-1:0] FULL =
    PWM_BITS'((DUTY_FULL > DUTY_MAX) ? DUTY_MAX : DUTY_FULL);
  localparam logic [PWM_BITS-1:0] SLOW =
    PWM_BITS'((DUTY_SLOW > DUTY_MAX) ? DUTY_MAX : DUTY_SLOW);
  localparam int unsigned DW = $clog2(DEADTIME + 2);
  localparam logic [1:0] FWD = 2'b10;
  localparam logic [1:0] REV = 2'b01;
  localparam logic [1:0] OFF = 2'b00;

  typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_DEAD} wheel_state_t;

  // Index 0 is the left wheel, index 1 the right wheel.
  logic [1:0][1:0]          dir_req;
  logic [1:0][PWM_BITS-1:0] target;
  logic [1:0][PWM_BITS-1:0] duty;
  logic [1:0][1:0]          pins;
  logic [1:0]               dead;
  logic [PWM_BITS-1:0]      cnt;
  logic [PWM_BITS-1:0]      eff_l, eff_r;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    dir_req = '0;
    target  = '0;
    case (mode)
      5'd3, 5'd5: begin dir_req[0] = FWD; target[0] = FULL; dir_req[1] = FWD; target[1] = FULL; end
      5'd4:       begin dir_req[0] = FWD; target[0] = SLOW; dir_req[1] = FWD; target[1] = SLOW; end
      5'd6:       begin dir_req[0] = REV; target[0] = SLOW; dir_req[1] = FWD; target[1] = FULL; end
      5'd7:       begin dir_req[0] = FWD; target[0] = FULL; dir_req[1] = REV; target[1] = SLOW; end
      5'd8:       begin dir_req[0] = FWD; target[0] = SLOW; dir_req[1] = FWD; target[1] = FULL; end
      5'd9:       begin dir_req[0] = FWD; target[0] = FULL; dir_req[1] = FWD; target[1] = SLOW; end
      default:    ;
    endcase
  end

  // Effective duty only reloads at the wrap, so no period is ever cut short or stretched.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      eff_l <= '0;
      eff_r <= '0;
    end else begin
      cnt <= cnt + PWM_BITS'(1);
      if (&cnt) begin
        eff_l <= duty[0];
        eff_r <= duty[1];
      end
    end
  end

  assign pwm_l  = (cnt < eff_l);
  assign pwm_r  = (cnt < eff_r);
  assign l_in   = pins[0];
  assign r_in   = pins[1];
  assign dead_l = dead[0];
  assign dead_r = dead[1];

`ifndef MOTOR_SOFT_RAMP_EN
  // RAMP_DIV only has meaning when the ramp is compiled in.
  logic unused_ramp_div;
  assign unused_ramp_div = (RAMP_DIV == 0);
`endif

  for (genvar w = 0; w < 2; w++) begin : g_wheel
    wheel_state_t        state, state_nx;
    logic [1:0]          dir_app;
    logic [DW-1:0]       dead_cnt;
    logic [PWM_BITS-1:0] duty_cur;
    logic [1:0]          pins_w;
    logic                dead_w;
    logic                hold_run;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state    <= ST_OFF;
        dir_app  <= OFF;
        dead_cnt <= '0;
      end else begin
        state <= state_nx;
        if (state != ST_RUN && state_nx == ST_RUN) dir_app <= dir_req[w];
        if (state == ST_RUN && state_nx == ST_DEAD) dead_cnt <= DW'(DEADTIME);
        else if (state_nx == ST_DEAD)               dead_cnt <= dead_cnt - DW'(1);
        else                                        dead_cnt <= '0;
      end
    end

    // A request matching the still-applied direction during DEAD aborts the reversal.
    always_comb begin
      state_nx = state;
      case (state)
        ST_OFF:  if (dir_req[w] != OFF) state_nx = ST_RUN;
        ST_RUN:  if (dir_req[w] == OFF)          state_nx = ST_OFF;
                 else if (dir_req[w] != dir_app) state_nx = ST_DEAD;
        ST_DEAD: if (dir_req[w] == OFF)                                state_nx = ST_OFF;
                 else if (dir_req[w] == dir_app || dead_cnt <= DW'(1)) state_nx = ST_RUN;
        default: state_nx = ST_OFF;
      endcase
    end

    always_comb begin
      pins_w = OFF;
      dead_w = 1'b0;
      case (state)
        ST_RUN:  pins_w = dir_app;
        ST_DEAD: dead_w = 1'b1;
        default: ;
      endcase
    end

    assign hold_run = (state == ST_RUN) && (state_nx == ST_RUN);

`ifdef MOTOR_SOFT_RAMP_EN
    localparam int unsigned RW = $clog2(RAMP_DIV + 1);
    logic [RW-1:0] ramp_cnt;

    // Rises one step per RAMP_DIV clocks; any decrease lands immediately.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_cur <= '0;
        ramp_cnt <= '0;
      end else if (hold_run) begin
        if (target[w] < duty_cur) begin
          duty_cur <= target[w];
          ramp_cnt <= '0;
        end else if (duty_cur < target[w]) begin
          if (ramp_cnt == RW'(RAMP_DIV - 1)) begin
            duty_cur <= duty_cur + PWM_BITS'(1);
            ramp_cnt <= '0;
          end else begin
            ramp_cnt <= ramp_cnt + RW'(1);
          end
        end else begin
          ramp_cnt <= '0;
        end
      end else begin
        duty_cur <= '0;
        ramp_cnt <= '0;
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst)           duty_cur <= '0;
      else if (hold_run) duty_cur <= target[w];
      else               duty_cur <= '0;
    end
`endif

    assign pins[w] = pins_w;
    assign dead[w] = dead_w;
    assign duty[w] = duty_cur;
  end
endmodule
